// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: handshake bundle between the fetch controller, the instruction
// memory port and the execute stage.
//   mem_req      - instruction read request (controller -> memory)
//   mem_ready    - instruction data valid this cycle (memory -> controller)
//   mem_err      - instruction bus error this cycle (memory -> controller)
//   ir_load      - instruction register load enable (controller -> datapath)
//   pc_load      - program counter load enable (controller -> datapath)
//   pc_sel[1:0]  - PC source: 0 PC+4, 1 branch target, 2 trap vector
//   exec_valid   - one-cycle pulse, IR holds a new instruction
//   exec_done    - execute stage finished the current instruction
//   branch_taken - valid with exec_done
//   halt         - valid with exec_done; stop after this instruction
// Modports: master = fetch controller side, slave = memory/datapath side.
interface fetch_ctrl_if;
    logic       mem_req;
    logic       mem_ready;
    logic       mem_err;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic       exec_valid;
    logic       exec_done;
    logic       branch_taken;
    logic       halt;

    modport master (
        output mem_req, ir_load, pc_load, pc_sel, exec_valid,
        input  mem_ready, mem_err, exec_done, branch_taken, halt
    );

    modport slave (
        input  mem_req, ir_load, pc_load, pc_sel, exec_valid,
        output mem_ready, mem_err, exec_done, branch_taken, halt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch/execute sequencing FSM.
//   IDLE -> FETCH -> WAIT -> DECODE -> EXEC -> (FETCH | IDLE), with TRAP on a
//   bus error (or on a memory-wait timeout when FETCH_TIMEOUT_EN is defined).
// Ports:
//   clk            - clock, rising edge
//   rstn           - synchronous active-low reset
//   start          - leave IDLE/TRAP and begin fetching
//   bus            - fetch_ctrl_if.master (memory + execute handshakes)
//   trap           - high for every cycle spent in TRAP
//   trap_cause[1:0]- 0 none, 1 bus error, 2 timeout
//   state[2:0]     - current FSM state (IDLE=0 .. TRAP=5)
//   instret        - retired-instruction count, wraps silently
// Configuration macro: FETCH_TIMEOUT_EN enables the WAIT timeout counter
// (TIMEOUT_CYCLES WAIT cycles without mem_ready/mem_err -> TRAP, cause 2).
module fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    fetch_ctrl_if.master         bus,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] instret
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StWait   = 3'd2,
        StDecode = 3'd3,
        StExec   = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           cause_q, cause_d;
    logic                 trap_entry_q;   // first cycle in TRAP: load the trap vector
    logic [CNT_WIDTH-1:0] instret_q;
    logic                 timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned ToWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToWidth-1:0] to_cnt_q;

    // FETCH always precedes WAIT, so clearing there clears on WAIT entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else if (state_q == StFetch) begin
            to_cnt_q <= '0;
        end else if (state_q == StWait) begin
            to_cnt_q <= to_cnt_q + ToWidth'(1);
        end
    end

    // Counter holds (n-1) in the n-th WAIT cycle.
    assign timeout_hit = (state_q == StWait) && (to_cnt_q == ToWidth'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cause_q      <= 2'd0;
            trap_entry_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            trap_entry_q <= (state_d == StTrap) && (state_q != StTrap);
            if (state_q == StExec && bus.exec_done) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch:  state_d = StWait;
            StWait: begin
                // Bus error beats data; data beats timeout.
                if (bus.mem_err) begin
                    state_d = StTrap;
                    cause_d = 2'd1;
                end else if (bus.mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                    cause_d = 2'd2;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (bus.exec_done) state_d = bus.halt ? StIdle : StFetch;
            end
            StTrap: begin
                if (start) begin
                    state_d = StFetch;
                    cause_d = 2'd0;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.ir_load    = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_sel     = 2'd0;
        bus.exec_valid = 1'b0;
        trap           = 1'b0;
        case (state_q)
            StFetch:  bus.mem_req = 1'b1;
            StWait: begin
                bus.mem_req = 1'b1;
                bus.ir_load = bus.mem_ready & ~bus.mem_err;
            end
            StDecode: bus.exec_valid = 1'b1;
            StExec: begin
                if (bus.exec_done) begin
                    bus.pc_load = 1'b1;
                    bus.pc_sel  = bus.branch_taken ? 2'd1 : 2'd0;
                end
            end
            StTrap: begin
                trap = 1'b1;
                if (trap_entry_q) begin
                    bus.pc_load = 1'b1;
                    bus.pc_sel  = 2'd2;
                end
            end
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign state      = state_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven bench for fetch_ctrl (CNT_WIDTH=2 so the
// retired counter wraps after four instructions).
module tb_fetch_ctrl;
    logic       clk;
    logic       rstn;
    logic       start;
    logic       trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
    logic [1:0] instret;

    int errors = 0;
    int checks = 0;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH     (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .bus       (bus),
        .trap      (trap),
        .trap_cause(trap_cause),
        .state     (state),
        .instret   (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Input patterns: {rstn, start, mem_ready, mem_err, exec_done, branch_taken, halt}
    localparam logic [6:0] RST     = 7'b0000000;
    localparam logic [6:0] NONE    = 7'b1000000;
    localparam logic [6:0] START   = 7'b1100000;
    localparam logic [6:0] RDY     = 7'b1010000;
    localparam logic [6:0] RDYERR  = 7'b1011000;
    localparam logic [6:0] DONE    = 7'b1000100;
    localparam logic [6:0] DONEBR  = 7'b1000110;
    localparam logic [6:0] DONEHLT = 7'b1000101;

    typedef struct {
        logic [6:0]  in;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check invariants.
    task automatic drive(input logic [6:0] in);
        @(negedge clk);
        {rstn, start, bus.mem_ready, bus.mem_err, bus.exec_done, bus.branch_taken,
         bus.halt} = in;
        #1;
        chk("ir_pc_exclusive", 32'(bus.ir_load & bus.pc_load), 32'd0);
        chk("pc_sel_without_load", 32'(!bus.pc_load && bus.pc_sel != 2'd0), 32'd0);
    endtask

    function automatic logic [13:0] outs();
        return {state, bus.mem_req, bus.ir_load, bus.pc_load, bus.pc_sel, bus.exec_valid,
                trap, trap_cause, instret};
    endfunction

    function automatic logic [13:0] e(input int st, input int req, input int irl,
                                      input int pcl, input int psel, input int ev,
                                      input int trp, input int cause, input int ir);
        return {3'(st), 1'(req), 1'(irl), 1'(pcl), 2'(psel), 1'(ev), 1'(trp), 2'(cause),
                2'(ir)};
    endfunction

    function automatic vec_t v(input logic [6:0] in, input logic [13:0] exp);
        vec_t r;
        r.in  = in;
        r.exp = exp;
        return r;
    endfunction

    initial begin
        rstn              = 1'b0;
        start             = 1'b0;
        bus.mem_ready     = 1'b0;
        bus.mem_err       = 1'b0;
        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.halt          = 1'b0;
        repeat (2) @(posedge clk);

        // Each row: inputs for this cycle, outputs expected in this cycle.
        //                     st req irl pcl sel ev trp cause instret
        vecs.push_back(v(RST,    e(0, 0, 0, 0, 0, 0, 0, 0, 0)));  // reset state
        vecs.push_back(v(RDYERR, e(0, 0, 0, 0, 0, 0, 0, 0, 0)));  // IDLE ignores memory
        vecs.push_back(v(START,  e(0, 0, 0, 0, 0, 0, 0, 0, 0)));  // cycle 1
        vecs.push_back(v(NONE,   e(1, 1, 0, 0, 0, 0, 0, 0, 0)));  // FETCH
        vecs.push_back(v(RDY,    e(2, 1, 1, 0, 0, 0, 0, 0, 0)));  // cycle 3 ir_load
        vecs.push_back(v(NONE,   e(3, 0, 0, 0, 0, 1, 0, 0, 0)));  // cycle 4 exec_valid
        vecs.push_back(v(DONE,   e(4, 0, 0, 1, 0, 0, 0, 0, 0)));  // cycle 5 pc_load
        vecs.push_back(v(NONE,   e(1, 1, 0, 0, 0, 0, 0, 0, 1)));  // instret=1
        vecs.push_back(v(NONE,   e(2, 1, 0, 0, 0, 0, 0, 0, 1)));  // WAIT holds
        vecs.push_back(v(RDY,    e(2, 1, 1, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(NONE,   e(3, 0, 0, 0, 0, 1, 0, 0, 1)));
        vecs.push_back(v(NONE,   e(4, 0, 0, 0, 0, 0, 0, 0, 1)));  // EXEC holds
        vecs.push_back(v(DONEBR, e(4, 0, 0, 1, 1, 0, 0, 0, 1)));  // branch target
        vecs.push_back(v(NONE,   e(1, 1, 0, 0, 0, 0, 0, 0, 2)));
        vecs.push_back(v(RDYERR, e(2, 1, 0, 0, 0, 0, 0, 0, 2)));  // error beats ready
        vecs.push_back(v(NONE,   e(5, 0, 0, 1, 2, 0, 1, 1, 2)));  // trap vector
        vecs.push_back(v(RDY,    e(5, 0, 0, 0, 0, 0, 1, 1, 2)));  // trap held
        vecs.push_back(v(START,  e(5, 0, 0, 0, 0, 0, 1, 1, 2)));
        vecs.push_back(v(NONE,   e(1, 1, 0, 0, 0, 0, 0, 0, 2)));  // trap cleared
        vecs.push_back(v(RDY,    e(2, 1, 1, 0, 0, 0, 0, 0, 2)));
        vecs.push_back(v(NONE,   e(3, 0, 0, 0, 0, 1, 0, 0, 2)));
        vecs.push_back(v(DONE,   e(4, 0, 0, 1, 0, 0, 0, 0, 2)));
        vecs.push_back(v(NONE,   e(1, 1, 0, 0, 0, 0, 0, 0, 3)));
        vecs.push_back(v(RDY,    e(2, 1, 1, 0, 0, 0, 0, 0, 3)));
        vecs.push_back(v(NONE,   e(3, 0, 0, 0, 0, 1, 0, 0, 3)));
        vecs.push_back(v(NONE,   e(4, 0, 0, 0, 0, 0, 0, 0, 3)));
        vecs.push_back(v(RST,    e(4, 0, 0, 0, 0, 0, 0, 0, 3)));  // reset mid-EXEC
        vecs.push_back(v(RDY,    e(0, 0, 0, 0, 0, 0, 0, 0, 0)));  // late ready ignored
        vecs.push_back(v(RDY,    e(0, 0, 0, 0, 0, 0, 0, 0, 0)));

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Four instructions, the last with halt: counter wraps 3 -> 0.
        drive(START);
        for (int i = 0; i < 4; i++) begin
            drive(NONE);
            chk("seq_fetch_state", 32'(state), 32'd1);
            chk("seq_instret", 32'(instret), 32'(i));
            drive(RDY);
            chk("seq_ir_load", 32'(bus.ir_load), 32'd1);
            drive(NONE);
            chk("seq_exec_valid", 32'(bus.exec_valid), 32'd1);
            drive((i == 3) ? DONEHLT : DONE);
            chk("seq_pc_load", 32'(bus.pc_load), 32'd1);
        end
        drive(RDY);
        chk("halt_state", 32'(state), 32'd0);
        chk("instret_wrap", 32'(instret), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(RDY);
            chk("halt_no_req", 32'(bus.mem_req), 32'd0);
        end
        drive(START);
        drive(NONE);
        chk("restart_fetch", 32'(state), 32'd1);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            drive(NONE);
            chk("to_wait_state", 32'(state), 32'd2);
        end
        drive(NONE);  // 16th WAIT cycle
        chk("to_wait16_state", 32'(state), 32'd2);
        drive(NONE);
        chk("to_trap_state", 32'(state), 32'd5);
        chk("to_trap_cause", 32'(trap_cause), 32'd2);
        chk("to_trap_vec", 32'({bus.pc_load, bus.pc_sel}), 32'({1'b1, 2'd2}));
        drive(START);
        chk("to_trap_held", 32'(trap), 32'd1);
        drive(NONE);
        chk("to_exit_state", 32'(state), 32'd1);
        chk("to_exit_trap", 32'({trap, trap_cause}), 32'd0);
        for (int i = 0; i < 15; i++) drive(NONE);
        drive(RDY);  // ready on the 16th cycle wins
        chk("to_ready16_irl", 32'(bus.ir_load), 32'd1);
        drive(NONE);
        chk("to_ready16_decode", 32'(state), 32'd3);
`else
        for (int i = 0; i < 40; i++) begin
            drive(NONE);
            chk("nto_wait_state", 32'(state), 32'd2);
            chk("nto_no_cause", 32'(trap_cause), 32'd0);
        end
        drive(RDY);
        chk("nto_ir_load", 32'(bus.ir_load), 32'd1);
        drive(NONE);
        chk("nto_decode", 32'(state), 32'd3);
`endif
        drive(DONEHLT);
        chk("final_pc_load", 32'({bus.pc_load, bus.pc_sel}), 32'({1'b1, 2'd0}));
        drive(NONE);
        chk("final_idle", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
